// File: rtl/updi_phy_if.sv
// Byte-level handshake between the UPDI bridge and the PHY.
// The bridge is master; the PHY is slave.
interface updi_phy_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       send_break;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       busy;

  modport master (
    output tx_data, tx_valid, send_break,
    input  tx_ready, rx_data, rx_valid,
    input  rx_parity_err, rx_frame_err, busy
  );

  modport slave (
    input  tx_data, tx_valid, send_break,
    output tx_ready, rx_data, rx_valid,
    output rx_parity_err, rx_frame_err, busy
  );
endinterface

// File: rtl/updi_phy.sv
// UPDI single-wire PHY: 8E2 frame TX/RX plus BREAK generation.
// Half-duplex; the receiver is blind while the line is driven.
module updi_phy #(
  parameter int CLKS_PER_BIT = 100,
  parameter int BREAK_BITS   = 24
) (
  input  logic clk,
  input  logic rst,
  updi_phy_if.slave bus,
  output logic updi_tx,
  output logic updi_tx_en,
  input  logic updi_rx
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BMAX = (BREAK_BITS > 11) ? BREAK_BITS : 11;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BRK_LAST = BW'(BREAK_BITS);
  localparam logic [BW-1:0] TX_LAST  = BW'(11);
  localparam logic [BW-1:0] RX_PAR   = BW'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_TX,
    S_RX_START,
    S_RX_BITS,
    S_RX_WAIT
  } state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [BW-1:0] r_bit, w_bit_n;
  logic [11:0]   r_frame, w_frame_n;
  logic [7:0]    r_rxsh, w_rxsh_n;
  logic          r_rxpar, w_rxpar_n;
  logic [7:0]    r_rx_data, w_rx_data_n;
  logic          r_perr, w_perr_n;
  logic          r_ferr, w_ferr_n;
  logic          r_rx_valid, w_rx_valid_n;
  logic          r_sync1, r_sync2, r_sync_d;

  logic w_fall, w_bit_end, w_half, w_drive;

  assign w_fall    = r_sync_d & ~r_sync2;
  assign w_bit_end = (r_cnt == CNT_MAX);
  assign w_half    = (r_cnt == HALF_MAX);
  assign w_drive   = (r_state == S_BREAK) ||
                     (r_state == S_TX);

  // History forced high while driving so the echo never looks like a start
  always_ff @(posedge clk) begin
    if (rst || w_drive) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= updi_rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_frame    <= '1;
      r_rxsh     <= '0;
      r_rxpar    <= 1'b0;
      r_rx_data  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bit      <= w_bit_n;
      r_frame    <= w_frame_n;
      r_rxsh     <= w_rxsh_n;
      r_rxpar    <= w_rxpar_n;
      r_rx_data  <= w_rx_data_n;
      r_perr     <= w_perr_n;
      r_ferr     <= w_ferr_n;
      r_rx_valid <= w_rx_valid_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = w_bit_end ? '0 : r_cnt + CW'(1);
    w_bit_n      = r_bit;
    w_frame_n    = r_frame;
    w_rxsh_n     = r_rxsh;
    w_rxpar_n    = r_rxpar;
    w_rx_data_n  = r_rx_data;
    w_perr_n     = r_perr;
    w_ferr_n     = r_ferr;
    w_rx_valid_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_bit_n = '0;
        if (bus.send_break) begin
          w_state_n = S_BREAK;
        end else if (bus.tx_valid) begin
          w_frame_n = {2'b11, ^bus.tx_data,
                       bus.tx_data, 1'b0};
          w_state_n = S_TX;
        end else if (w_fall) begin
          w_state_n = S_RX_START;
        end
      end
      S_BREAK: begin
        if (w_bit_end) begin
          w_bit_n = r_bit + BW'(1);
          if (r_bit == BRK_LAST) w_state_n = S_IDLE;
        end
      end
      S_TX: begin
        if (w_bit_end) begin
          w_frame_n = {1'b1, r_frame[11:1]};
          w_bit_n   = r_bit + BW'(1);
          if (r_bit == TX_LAST) w_state_n = S_IDLE;
        end
      end
      S_RX_START: begin
        if (w_half) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = r_sync2 ? S_IDLE : S_RX_BITS;
        end
      end
      S_RX_BITS: begin
        if (w_bit_end) begin
          w_bit_n = r_bit + BW'(1);
          if (r_bit < RX_PAR) begin
            w_rxsh_n = {r_sync2, r_rxsh[7:1]};
          end else if (r_bit == RX_PAR) begin
            w_rxpar_n = r_sync2;
          end else begin
            w_rx_valid_n = 1'b1;
            w_rx_data_n  = r_rxsh;
            w_perr_n     = r_rxpar ^ (^r_rxsh);
            w_ferr_n     = ~r_sync2;
            w_state_n    = r_sync2 ? S_IDLE : S_RX_WAIT;
          end
        end
      end
      S_RX_WAIT: begin
        w_cnt_n = '0;
        if (r_sync2) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign updi_tx_en = w_drive;
  assign updi_tx    = (r_state == S_BREAK) ? (r_bit == BRK_LAST) :
                      (r_state == S_TX)    ? r_frame[0] : 1'b1;

  assign bus.tx_ready      = (r_state == S_IDLE) &&
                             !bus.send_break && !rst;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_parity_err = r_perr;
  assign bus.rx_frame_err  = r_ferr;

endmodule

// File: tb/tb_updi_phy.sv
// Self-checking bench for updi_phy: table + random frames vs a
// frame-level reference model, plus BREAK/glitch/reset sequences.
module tb_updi_phy;
  localparam int CPB = 4;
  localparam int BB  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic updi_tx, updi_tx_en;
  logic r_ext = 1'b1;
  logic line;

  // Open-drain line with pull-up; the target sees our own drive (echo)
  assign line = updi_tx_en ? updi_tx : r_ext;

  updi_phy_if bus();

  updi_phy #(.CLKS_PER_BIT(CPB), .BREAK_BITS(BB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .updi_tx(updi_tx),
    .updi_tx_en(updi_tx_en),
    .updi_rx(line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } rx_t;
  rx_t rx_q[$];

  always @(negedge clk)
    if (bus.rx_valid === 1'b1)
      rx_q.push_back('{bus.rx_data, bus.rx_parity_err,
                       bus.rx_frame_err, cyc});

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic par8(logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Frame bit i of an 8E2 frame: start, d0..d7, even parity, 2 stops
  function automatic logic frame_bit(logic [7:0] d, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9) return par8(d);
    return 1'b1;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (bus.tx_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("tx_ready_wait", 32'(bus.tx_ready), 32'(1));
  endtask

  task automatic tx_frame(logic [7:0] d);
    wait_ready();
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 12 * CPB; i++) begin
      chk($sformatf("tx_bit%0d", i / CPB),
          32'({updi_tx_en, updi_tx}),
          32'({1'b1, frame_bit(d, i / CPB)}));
      chk("tx_busy_ready", 32'({bus.busy, bus.tx_ready}), 32'(2'b10));
      @(negedge clk);
    end
    chk("tx_done", 32'({updi_tx_en, bus.tx_ready}), 32'(2'b01));
  endtask

  task automatic rx_frame(logic [7:0] d, logic p, logic stop,
                          int hold, output int t0);
    logic lvl;
    t0 = cyc + 1;
    for (int i = 0; i < 11; i++) begin
      lvl = (i < 9) ? frame_bit(d, i) : (i == 9) ? p : stop;
      r_ext = lvl;
      repeat (CPB) @(negedge clk);
    end
    if (!stop) begin
      repeat (hold * CPB / 2) @(negedge clk);
      chk("rxwait_busy", 32'(bus.busy), 32'(1));
      repeat (hold * CPB - hold * CPB / 2) @(negedge clk);
    end
    r_ext = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("rx_back_idle", 32'(bus.busy), 32'(0));
  endtask

  task automatic rx_expect(logic [7:0] d, logic p, logic stop, int t0);
    rx_t e;
    int lat;
    chk("rx_count", 32'(rx_q.size()), 32'(1));
    if (rx_q.size() > 0) begin
      e = rx_q.pop_front();
      chk("rx_data", 32'(e.d), 32'(d));
      chk("rx_perr", 32'(e.pe), 32'(p != par8(d)));
      chk("rx_ferr", 32'(e.fe), 32'(!stop));
      lat = e.at - (t0 + 2 + CPB / 2 + 10 * CPB);
      chk("rx_latency", 32'(lat >= -1 && lat <= 1), 32'(1));
    end
    rx_q.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    int         hold;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t vt[6];

  initial begin
    int t0;
    logic [7:0] d;
    logic p, s;
    rx_t e;

    vt[0] = '{8'h07, 1'b1, 1'b1, 0,  8'h07, 1'b0, 1'b0};
    vt[1] = '{8'h07, 1'b0, 1'b1, 0,  8'h07, 1'b1, 1'b0};
    vt[2] = '{8'hA3, 1'b0, 1'b0, 30, 8'hA3, 1'b0, 1'b1};
    vt[3] = '{8'h00, 1'b0, 1'b1, 0,  8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 1'b1, 1'b1, 0,  8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'h80, 1'b1, 1'b1, 0,  8'h80, 1'b0, 1'b0};

    bus.tx_data    = 8'h00;
    bus.tx_valid   = 1'b0;
    bus.send_break = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line", 32'({updi_tx_en, updi_tx}), 32'(2'b01));
    chk("rst_rx", 32'({bus.rx_valid, bus.rx_data,
        bus.rx_parity_err, bus.rx_frame_err}), 32'(0));
    chk("rst_busy_ready", 32'({bus.busy, bus.tx_ready}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.tx_ready), 32'(1));

    tx_frame(8'h55);
    tx_frame(8'hC3);
    repeat (8) @(negedge clk);
    chk("no_echo_rx", 32'(rx_q.size()), 32'(0));

    for (int i = 0; i < 6; i++) begin
      rx_frame(vt[i].d, vt[i].p, vt[i].stop, vt[i].hold, t0);
      chk($sformatf("vec%0d_count", i), 32'(rx_q.size()), 32'(1));
      if (rx_q.size() > 0) begin
        e = rx_q.pop_front();
        chk($sformatf("vec%0d_data", i), 32'(e.d), 32'(vt[i].ed));
        chk($sformatf("vec%0d_flags", i),
            32'({e.pe, e.fe}), 32'({vt[i].epe, vt[i].efe}));
        chk($sformatf("vec%0d_lat", i), 32'(e.at - t0), 32'(44));
      end
      rx_q.delete();
    end

    // BREAK wins over a coincident byte
    wait_ready();
    bus.tx_data    = 8'hAA;
    bus.tx_valid   = 1'b1;
    bus.send_break = 1'b1;
    #1;
    chk("brk_ready_low", 32'(bus.tx_ready), 32'(0));
    @(negedge clk);
    bus.tx_valid   = 1'b0;
    bus.send_break = 1'b0;
    for (int i = 0; i < (BB + 1) * CPB; i++) begin
      chk($sformatf("brk_line%0d", i),
          32'({updi_tx_en, updi_tx}),
          32'({1'b1, i >= BB * CPB}));
      chk("brk_ready", 32'(bus.tx_ready), 32'(0));
      @(negedge clk);
    end
    chk("brk_done", 32'({updi_tx_en, bus.tx_ready}), 32'(2'b01));
    repeat (2 * CPB) @(negedge clk);
    chk("brk_no_tx", 32'(updi_tx_en), 32'(0));
    chk("brk_no_rx", 32'(rx_q.size()), 32'(0));

    // One-cycle glitch: false start
    r_ext = 1'b0;
    @(negedge clk);
    r_ext = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("glitch_detect", 32'(bus.busy), 32'(1));
    @(negedge clk);
    @(negedge clk);
    chk("glitch_idle", 32'(bus.busy), 32'(0));
    repeat (12 * CPB) @(negedge clk);
    chk("glitch_no_rx", 32'(rx_q.size()), 32'(0));

    // Reset in the middle of TX bit 5
    wait_ready();
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (5 * CPB + 1) @(negedge clk);
    chk("mid_tx_bit5", 32'({updi_tx_en, updi_tx}), 32'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", 32'({updi_tx_en, updi_tx, bus.tx_ready,
        bus.rx_valid, bus.busy}), 32'(5'b01000));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", 32'(bus.tx_ready), 32'(1));
    repeat (12 * CPB) @(negedge clk);
    chk("mid_rst_no_rx", 32'(rx_q.size()), 32'(0));
    chk("mid_rst_idle", 32'({updi_tx_en, bus.busy}), 32'(0));

    // Random traffic against the frame model
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      if ($urandom_range(1) == 1) begin
        tx_frame(d);
      end else begin
        p = 1'($urandom_range(1));
        s = ($urandom_range(3) != 0);
        rx_frame(d, p, s, 1 + $urandom_range(3), t0);
        rx_expect(d, p, s, t0);
      end
      repeat ($urandom_range(5)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("final_no_rx", 32'(rx_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
